// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state shared by the sequential ALU.
package alu_pkg;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_ADD   = 5'h04;
  localparam logic [4:0] OP_AND   = 5'h05;
  localparam logic [4:0] OP_XOR   = 5'h06;
  localparam logic [4:0] OP_SUB   = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_LUI   = 5'h0B;
  localparam logic [4:0] OP_SLT   = 5'h0C;
  localparam logic [4:0] OP_SLTU  = 5'h0D;
  localparam logic [4:0] OP_NOR   = 5'h0E;
  localparam logic [4:0] OP_PASS  = 5'h0F;
  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_MULTU = 5'h11;
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_DIVU  = 5'h13;
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle shift-add multiply / restoring divide on magnitudes.
module alu_iter_muldiv #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic               r_busy, r_div, r_neg_hi, r_neg_lo;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p, w_p, w_prod;
  logic [WIDTH:0]     w_sum, w_rs, w_diff;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;
  // r_p holds {hi,lo} for multiply and {remainder,quotient} for divide
  assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_p[0]}} & {1'b0, r_m});
  assign w_rs   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff = w_rs - {1'b0, r_m};
  assign w_p    = r_div ? {w_diff[WIDTH] ? w_rs[WIDTH-1:0] : w_diff[WIDTH-1:0], r_p[WIDTH-2:0], ~w_diff[WIDTH]}
                        : {w_sum, r_p[WIDTH-1:1]};
  // final result is taken from the last step's value so it lands on the DONE edge
  assign w_prod = r_neg_lo ? -w_p : w_p;
  assign hi     = r_div ? (r_neg_hi ? -w_p[2*WIDTH-1:WIDTH] : w_p[2*WIDTH-1:WIDTH]) : w_prod[2*WIDTH-1:WIDTH];
  assign lo     = r_div ? (r_neg_lo ? -w_p[WIDTH-1:0] : w_p[WIDTH-1:0]) : w_prod[WIDTH-1:0];
  assign done   = r_busy && r_cnt == CW'(WIDTH-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
      r_m      <= '0;
      r_p      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_div    <= is_div;
      r_neg_hi <= w_a_neg;
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_m      <= is_div ? w_b_mag : w_a_mag;
      r_p      <= {{WIDTH{1'b0}}, is_div ? w_a_mag : w_b_mag};
    end else if (r_busy) begin
      r_p    <= w_p;
      r_cnt  <= r_cnt + 1'b1;
      r_busy <= !done;
    end
  end
endmodule

// File: rtl/exe_alu_seq.sv
// exe_alu_seq: single-cycle ALU with iterative MULT/DIV and architectural HI/LO.
module exe_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         operation,
  input  logic [WIDTH-1:0]   Op1,
  input  logic [WIDTH-1:0]   Op2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   EXE_Result,
  output logic               EXE_Zero,
  output logic               Overflow,
  output logic               DivByZero,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           r_state;
  logic             r_ovf_pend;
  logic             w_acc, w_is_div, w_dbz, w_start, w_signed, w_ovf, w_done;
  logic [WIDTH-1:0] w_res, w_sum, w_dif, w_hi, w_lo;
  assign in_ready = r_state == S_IDLE && !rst;
  assign w_acc    = in_valid && in_ready;
  assign w_is_div = operation == OP_DIV || operation == OP_DIVU;
  assign w_dbz    = w_is_div && Op2 == '0;
  assign w_start  = w_acc && (operation == OP_MULT || operation == OP_MULTU || (w_is_div && !w_dbz));
  assign w_signed = operation == OP_MULT || operation == OP_DIV;
  assign w_sum    = Op1 + Op2;
  assign w_dif    = Op2 - Op1;
  assign w_ovf    = operation == OP_ADD ? (Op1[WIDTH-1] == Op2[WIDTH-1] && w_sum[WIDTH-1] != Op1[WIDTH-1])
                  : operation == OP_SUB ? (Op2[WIDTH-1] != Op1[WIDTH-1] && w_dif[WIDTH-1] != Op2[WIDTH-1])
                  : 1'b0;
  always_comb begin
    w_res = '0;
    case (operation)
      OP_OR:   w_res = Op1 | Op2;
      OP_ADD:  w_res = w_sum;
      OP_AND:  w_res = Op1 & Op2;
      OP_XOR:  w_res = Op1 ^ Op2;
      OP_SUB:  w_res = w_dif;
      OP_SLL:  w_res = Op2 << shamt;
      OP_SRL:  w_res = Op2 >> shamt;
      OP_SRA:  w_res = $signed(Op2) >>> shamt;
      OP_LUI:  w_res = Op2 << 16;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(Op1) < $signed(Op2)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, Op1 < Op2};
      OP_NOR:  w_res = ~(Op1 | Op2);
      OP_PASS: w_res = Op2;
      OP_MFHI: w_res = HI;
      OP_MFLO: w_res = LO;
      default: w_res = '0;
    endcase
  end
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .start(w_start), .is_div(w_is_div), .is_signed(w_signed),
    .a(Op1), .b(Op2), .done(w_done), .hi(w_hi), .lo(w_lo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ovf_pend <= 1'b0;
      HI         <= '0;
      LO         <= '0;
      out_valid  <= 1'b0;
      EXE_Result <= '0;
      EXE_Zero   <= 1'b0;
      Overflow   <= 1'b0;
      DivByZero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state    <= w_is_div ? S_DIV : S_MUL;
          r_ovf_pend <= operation == OP_DIV && Op1 == MOST_NEG && Op2 == '1;
        end else if (w_acc) begin
          out_valid  <= 1'b1;
          EXE_Result <= w_res;
          EXE_Zero   <= w_res == '0;
          Overflow   <= w_ovf;
          DivByZero  <= w_dbz;
        end
        S_MUL, S_DIV: if (w_done) begin
          r_state    <= S_DONE;
          HI         <= w_hi;
          LO         <= w_lo;
          out_valid  <= 1'b1;
          EXE_Result <= w_lo;
          EXE_Zero   <= w_lo == '0;
          Overflow   <= r_ovf_pend;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_alu_seq.sv
// tb_exe_alu_seq: directed checks of a 64-bit and a 32-bit exe_alu_seq instance.
module tb_exe_alu_seq;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int n_pass = 0, n_tot = 0;
  logic        a_iv = 0, a_ir, a_ov, a_z, a_of, a_dz;
  logic [4:0]  a_opc = '0;
  logic [5:0]  a_sh = '0;
  logic [63:0] a_x = '0, a_y = '0, a_res, a_hi, a_lo;
  logic        b_iv = 0, b_ir, b_ov, b_z, b_of, b_dz;
  logic [4:0]  b_opc = '0;
  logic [4:0]  b_sh = '0;
  logic [31:0] b_x = '0, b_y = '0, b_res, b_hi, b_lo;
  exe_alu_seq #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .operation(a_opc),
    .Op1(a_x), .Op2(a_y), .shamt(a_sh), .out_valid(a_ov), .EXE_Result(a_res),
    .EXE_Zero(a_z), .Overflow(a_of), .DivByZero(a_dz), .HI(a_hi), .LO(a_lo)
  );
  exe_alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .operation(b_opc),
    .Op1(b_x), .Op2(b_y), .shamt(b_sh), .out_valid(b_ov), .EXE_Result(b_res),
    .EXE_Zero(b_z), .Overflow(b_of), .DivByZero(b_dz), .HI(b_hi), .LO(b_lo)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic a_op(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y, input logic [5:0] s);
    a_iv = 1; a_opc = op; a_x = x; a_y = y; a_sh = s;
    tick();
    a_iv = 0;
  endtask
  task automatic b_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    b_iv = 1; b_opc = op; b_x = x; b_y = y;
    tick();
    b_iv = 0;
  endtask
  // c = cycle number (1 = cycle after acceptance) at which out_valid is seen
  task automatic b_wait(output int c, output int low);
    c = 1;
    low = !b_ir ? 1 : 0;
    while (!b_ov && c < 100) begin
      tick();
      c++;
      if (!b_ir) low++;
    end
  endtask
  initial begin
    int c, low, nov;
    tick(); tick();
    chk("rst_ready64", a_ir, 0);
    chk("rst_ov64", a_ov, 0);
    chk("rst_hi64", a_hi, 0);
    chk("rst_lo32", b_lo, 0);
    chk("rst_res32", b_res, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", a_ir, 1);
    a_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("add_ov", a_ov, 1);
    chk("add_res", a_res, 64'h8000_0000_0000_0000);
    chk("add_of", a_of, 1);
    chk("add_z", a_z, 0);
    a_op(OP_SUB, 64'd5, 64'd5, 0);
    chk("sub_ov", a_ov, 1);
    chk("sub_res", a_res, 0);
    chk("sub_z", a_z, 1);
    chk("sub_of", a_of, 0);
    a_op(OP_SRA, 64'd0, 64'hF000_0000_0000_0000, 6'd4);
    chk("sra_res", a_res, 64'hFF00_0000_0000_0000);
    a_op(OP_SUB, 64'd1, 64'h8000_0000_0000_0000, 0);
    chk("sub_ovf_res", a_res, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf_of", a_of, 1);
    a_op(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("slt_res", a_res, 1);
    a_op(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("sltu_res", a_res, 0);
    chk("sltu_z", a_z, 1);
    a_op(OP_NOR, 64'd0, 64'd0, 0);
    chk("nor_res", a_res, 64'hFFFF_FFFF_FFFF_FFFF);
    a_op(OP_LUI, 64'd0, 64'h1234, 0);
    chk("lui_res", a_res, 64'h1234_0000);
    a_op(OP_SLL, 64'd0, 64'd1, 6'd63);
    chk("sll_res", a_res, 64'h8000_0000_0000_0000);
    a_op(OP_SRL, 64'd0, 64'h8000_0000_0000_0000, 6'd63);
    chk("srl_res", a_res, 1);
    a_op(OP_XOR, 64'hF0F0, 64'hFF00, 0);
    chk("xor_res", a_res, 64'h0FF0);
    a_op(OP_OR, 64'h0F, 64'hF0, 0);
    chk("or_res", a_res, 64'hFF);
    a_op(OP_AND, 64'h0FF, 64'hF0F, 0);
    chk("and_res", a_res, 64'h00F);
    a_op(OP_PASS, 64'h1, 64'hABCD, 0);
    chk("pass_res", a_res, 64'hABCD);
    chk("pass_of", a_of, 0);
    tick();
    chk("idle_ov", a_ov, 0);
    b_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    b_x = 32'hDEAD_BEEF; b_y = 32'h1234_5678;
    b_wait(c, low);
    chk("mult_cycle", c, 33);
    chk("mult_busy", low, 33);
    chk("mult_hi", b_hi, 32'hFFFF_FFFF);
    chk("mult_lo", b_lo, 32'hFFFF_FFEB);
    chk("mult_res", b_res, 32'hFFFF_FFEB);
    chk("mult_of", b_of, 0);
    tick();
    chk("mult_after_ready", b_ir, 1);
    chk("mult_after_ov", b_ov, 0);
    b_op(OP_MFHI, 0, 0);
    chk("mfhi_res", b_res, 32'hFFFF_FFFF);
    b_op(OP_MFLO, 0, 0);
    chk("mflo_res", b_res, 32'hFFFF_FFEB);
    b_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    b_wait(c, low);
    chk("multu_hi", b_hi, 32'hFFFF_FFFE);
    chk("multu_lo", b_lo, 32'h0000_0001);
    tick();
    b_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    b_wait(c, low);
    chk("div_cycle", c, 33);
    chk("div_lo", b_lo, 32'hFFFF_FFFD);
    chk("div_hi", b_hi, 32'hFFFF_FFFF);
    chk("div_of", b_of, 0);
    tick();
    b_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    b_wait(c, low);
    chk("divmn_of", b_of, 1);
    chk("divmn_lo", b_lo, 32'h8000_0000);
    chk("divmn_hi", b_hi, 0);
    chk("divmn_z", b_z, 0);
    tick();
    b_op(OP_DIVU, 32'h5555, 32'h100);
    b_wait(c, low);
    chk("divu_lo", b_lo, 32'h55);
    chk("divu_hi", b_hi, 32'h55);
    tick();
    b_op(OP_DIVU, 32'h1234, 32'd0);
    chk("dbz_ov", b_ov, 1);
    chk("dbz_flag", b_dz, 1);
    chk("dbz_res", b_res, 0);
    chk("dbz_hi", b_hi, 32'h55);
    chk("dbz_lo", b_lo, 32'h55);
    chk("dbz_ready", b_ir, 1);
    b_op(OP_MFLO, 0, 0);
    chk("mflo55_res", b_res, 32'h55);
    chk("mflo55_dz", b_dz, 0);
    b_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (10) tick();
    rst = 1;
    b_iv = 1; b_opc = OP_ADD; b_x = 1; b_y = 1;
    tick();
    chk("abort_hi", b_hi, 0);
    chk("abort_lo", b_lo, 0);
    chk("abort_ov", b_ov, 0);
    rst = 0;
    b_iv = 0;
    #1;
    chk("abort_ready", b_ir, 1);
    nov = 0;
    repeat (40) begin
      tick();
      if (b_ov) nov++;
    end
    chk("abort_no_ov", nov, 0);
    b_op(OP_ADD, 32'd2, 32'd3);
    chk("recover_res", b_res, 5);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
